// File: rtl/bin_to_bcd_if.sv
// bin_to_bcd_if: start/operand request and BCD result signals of the binary-to-BCD converter
interface bin_to_bcd_if #(parameter int IN_WIDTH = 14);
  logic start;
  logic [IN_WIDTH-1:0] bin_in;
  logic busy;
  logic done;
  logic overflow;
  logic [15:0] bcd_out;
  modport master(output start, bin_in, input busy, done, overflow, bcd_out);
  modport slave(input start, bin_in, output busy, done, overflow, bcd_out);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble converter, IN_WIDTH bits to four BCD digits.
// Define BCD_SATURATE_EN to clamp values above 9999 to 16'h9999 instead of keeping value mod 10000.
module bin_to_bcd_seq #(
  parameter int IN_WIDTH = 14
) (
  input logic clock,
  input logic reset_n,
  bin_to_bcd_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;
  logic [IN_WIDTH-1:0] sreg, sreg_nxt;
  logic [15:0] scratch, scratch_nxt, adj, shifted, result, bcd, bcd_nxt;
  logic [4:0] cnt, cnt_nxt;
  logic ovf_cap, ovf_cap_nxt, ovf, ovf_nxt;
  for (genvar d = 0; d < 4; d++) begin : g_adj
    assign adj[4*d+:4] = scratch[4*d+:4] >= 4'd5 ? scratch[4*d+:4] + 4'd3 : scratch[4*d+:4];
  end
  // The bit leaving the thousands digit is dropped, so the result is naturally value mod 10000.
  assign shifted = {adj[14:0], sreg[IN_WIDTH-1]};
`ifdef BCD_SATURATE_EN
  assign result = ovf_cap ? 16'h9999 : shifted;
`else
  assign result = shifted;
`endif
  always_comb begin
    state_nxt = state;
    sreg_nxt = sreg;
    scratch_nxt = scratch;
    cnt_nxt = cnt;
    ovf_cap_nxt = ovf_cap;
    bcd_nxt = bcd;
    ovf_nxt = ovf;
    case (state)
      IDLE: if (bus.start) begin
        state_nxt = SHIFT;
        sreg_nxt = bus.bin_in;
        scratch_nxt = '0;
        cnt_nxt = 5'(IN_WIDTH);
        ovf_cap_nxt = bus.bin_in > IN_WIDTH'(9999);
      end
      SHIFT: begin
        sreg_nxt = sreg << 1;
        scratch_nxt = shifted;
        cnt_nxt = cnt - 5'd1;
        if (cnt == 5'd1) begin
          state_nxt = DONE;
          bcd_nxt = result;
          ovf_nxt = ovf_cap;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      sreg <= '0;
      scratch <= '0;
      cnt <= '0;
      ovf_cap <= 1'b0;
      bcd <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      sreg <= sreg_nxt;
      scratch <= scratch_nxt;
      cnt <= cnt_nxt;
      ovf_cap <= ovf_cap_nxt;
      bcd <= bcd_nxt;
      ovf <= ovf_nxt;
    end
  end
  assign bus.busy = state == SHIFT;
  assign bus.done = state == DONE;
  assign bus.bcd_out = bcd;
  assign bus.overflow = ovf;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: vector table, corner sequences and randomized checks against an arithmetic model
module tb_bin_to_bcd_seq;
  localparam bit SAT =
`ifdef BCD_SATURATE_EN
    1'b1;
`else
    1'b0;
`endif
  typedef struct {
    int v;
    logic [15:0] b;
    logic o;
  } vec_t;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int passed = 0;
  bin_to_bcd_if #(.IN_WIDTH(14)) bif();
  bin_to_bcd_seq #(.IN_WIDTH(14)) dut(.clock(clock), .reset_n(reset_n), .bus(bif));
  always #5 clock = ~clock;
  function automatic logic [15:0] ref_bcd(int v);
    int t;
    t = v > 9999 ? (SAT ? 9999 : v % 10000) : v;
    return 16'(((t / 1000) << 12) | (((t / 100) % 10) << 8) | (((t / 10) % 10) << 4) | (t % 10));
  endfunction
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", n, a, e);
  endtask
  // Call just after a negedge; start is captured on the next posedge.
  task automatic conv_chk(string n, int v, logic [15:0] eb, logic eo);
    int busy_n, lat;
    bif.start = 1'b1;
    bif.bin_in = 14'(v);
    @(negedge clock);
    bif.start = 1'b0;
    bif.bin_in = 14'($urandom);
    busy_n = 0;
    lat = 1;
    while (!bif.done && lat < 40) begin
      if (bif.busy) busy_n++;
      @(negedge clock);
      lat++;
    end
    chk({n, " bcd"}, bif.bcd_out, eb);
    chk({n, " ovf"}, bif.overflow, eo);
    chk({n, " latency"}, lat, 15);
    chk({n, " busy cycles"}, busy_n, 14);
    @(negedge clock);
    chk({n, " done width"}, bif.done, 0);
  endtask
  initial begin
    vec_t tbl[8];
    int dones, v, last, cyc;
    logic [15:0] cap;
    tbl[0] = '{1234, 16'h1234, 1'b0};
    tbl[1] = '{0, 16'h0000, 1'b0};
    tbl[2] = '{9999, 16'h9999, 1'b0};
    tbl[3] = '{12345, SAT ? 16'h9999 : 16'h2345, 1'b1};
    tbl[4] = '{10000, SAT ? 16'h9999 : 16'h0000, 1'b1};
    tbl[5] = '{16383, SAT ? 16'h9999 : 16'h6383, 1'b1};
    tbl[6] = '{5, 16'h0005, 1'b0};
    tbl[7] = '{1050, 16'h1050, 1'b0};
    bif.start = 1'b0;
    bif.bin_in = '0;
    #3;
    chk("reset busy", bif.busy, 0);
    chk("reset done", bif.done, 0);
    chk("reset ovf", bif.overflow, 0);
    chk("reset bcd", bif.bcd_out, 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) conv_chk($sformatf("vec%0d", i), tbl[i].v, tbl[i].b, tbl[i].o);
    // Start while busy plus bin_in change after capture must be ignored.
    bif.start = 1'b1;
    bif.bin_in = 14'd42;
    @(negedge clock);
    bif.start = 1'b0;
    repeat (3) @(negedge clock);
    bif.start = 1'b1;
    bif.bin_in = 14'd77;
    @(negedge clock);
    bif.start = 1'b0;
    bif.bin_in = 14'd3000;
    dones = 0;
    cap = '0;
    for (int i = 0; i < 40; i++) begin
      if (bif.done) begin
        dones++;
        cap = bif.bcd_out;
      end
      @(negedge clock);
    end
    chk("ignore start dones", dones, 1);
    chk("ignore start bcd", cap, 16'h0042);
    chk("ignore start idle", bif.busy, 0);
    // Reset in the middle of a conversion.
    conv_chk("pre-abort", 5678, 16'h5678, 1'b0);
    bif.start = 1'b1;
    bif.bin_in = 14'd1111;
    @(negedge clock);
    bif.start = 1'b0;
    repeat (5) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("abort busy", bif.busy, 0);
    chk("abort done", bif.done, 0);
    chk("abort bcd", bif.bcd_out, 0);
    chk("abort ovf", bif.overflow, 0);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (bif.done) dones++;
    end
    chk("abort no done", dones, 0);
    reset_n = 1'b1;
    conv_chk("post-reset 321", 321, 16'h0321, 1'b0);
    for (int i = 0; i < 20; i++) begin
      v = int'($urandom_range(0, 16383));
      conv_chk($sformatf("rand %0d", v), v, ref_bcd(v), v > 9999);
    end
    // Start held high: sweep 0..9999 step 8, one result every 16 cycles.
    v = 0;
    last = -1;
    cyc = 0;
    bif.start = 1'b1;
    bif.bin_in = 14'd0;
    while (v <= 9999) begin
      dones = 0;
      while (!bif.done && dones < 40) begin
        @(negedge clock);
        cyc++;
        dones++;
      end
      if (dones >= 40) begin
        chk("sweep timeout", 0, 1);
        break;
      end
      if (bif.bcd_out !== ref_bcd(v) || bif.overflow !== 1'b0) chk($sformatf("sweep %0d", v), {bif.overflow, bif.bcd_out}, {1'b0, ref_bcd(v)});
      if (last >= 0 && cyc - last != 16) chk("sweep period", cyc - last, 16);
      last = cyc;
      v += 8;
      bif.bin_in = 14'(v);
      @(negedge clock);
      cyc++;
    end
    chk("sweep count", v, 10000);
    bif.start = 1'b0;
    repeat (20) @(negedge clock);
    chk("sweep final idle", bif.busy, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
